// File: rtl/spi_sub.sv
// SPI subordinate: oversamples SCLK/SS/MOSI on clk, shifts LSB-first frames in and out,
// and buffers one transmit word in a holding register.
module spi_sub #(
    parameter int DATA_WIDTH = 8,
    parameter bit CPOL       = 1'b1,
    parameter bit CPHA       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_SCLK,
    input  logic                  i_SS,
    input  logic                  i_MOSI,
    output logic                  o_MISO,
    output logic                  o_MISO_oe,
    input  logic [DATA_WIDTH-1:0] i_data_in_TX,
    input  logic                  i_data_valid_TX,
    output logic                  o_data_ready_TX,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_data_done,
    output logic                  o_tx_underrun,
    output logic                  o_frame_abort
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t                state_r;
    logic                  sclk_s1_r, sclk_s2_r, sclk_h_r;
    logic                  ss_s1_r, ss_s2_r, ss_h_r;
    logic                  mosi_s1_r, mosi_s2_r, mosi_h_r;
    logic [DATA_WIDTH-1:0] hold_r;
    logic                  hold_full_r;
    logic                  ready_r;
    logic [DATA_WIDTH-1:0] tx_shift_r;
    logic [DATA_WIDTH-1:0] rx_shift_r;
    logic [CW-1:0]         bit_cnt_r;
    logic                  reload_pending_r;
    logic                  first_lead_r;
    logic                  miso_r;
    logic                  oe_r;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  done_r;
    logic                  underrun_r;
    logic                  abort_r;

    logic                  lead_s, trail_s, sample_edge_s, shift_edge_s;
    logic                  ss_fall_s, ss_rise_s, last_sample_s;
    logic [DATA_WIDTH-1:0] load_word_s;
    logic [DATA_WIDTH-1:0] rx_word_s;

    // Two-flop synchronizers plus a history flop for edge detection
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_s1_r <= CPOL;
            sclk_s2_r <= CPOL;
            sclk_h_r  <= CPOL;
            ss_s1_r   <= 1'b1;
            ss_s2_r   <= 1'b1;
            ss_h_r    <= 1'b1;
            mosi_s1_r <= 1'b0;
            mosi_s2_r <= 1'b0;
            mosi_h_r  <= 1'b0;
        end else begin
            sclk_s1_r <= i_SCLK;
            sclk_s2_r <= sclk_s1_r;
            sclk_h_r  <= sclk_s2_r;
            ss_s1_r   <= i_SS;
            ss_s2_r   <= ss_s1_r;
            ss_h_r    <= ss_s2_r;
            mosi_s1_r <= i_MOSI;
            mosi_s2_r <= mosi_s1_r;
            mosi_h_r  <= mosi_s2_r;
        end
    end

    // Edge classification and next receive word
    always_comb begin
        lead_s        = (sclk_h_r == CPOL) && (sclk_s2_r != CPOL);
        trail_s       = (sclk_h_r != CPOL) && (sclk_s2_r == CPOL);
        sample_edge_s = CPHA ? trail_s : lead_s;
        shift_edge_s  = CPHA ? lead_s : trail_s;
        ss_fall_s     = ss_h_r & ~ss_s2_r;
        ss_rise_s     = ~ss_h_r & ss_s2_r;
        last_sample_s = (bit_cnt_r == CW'(DATA_WIDTH - 1));
        if (hold_full_r) begin
            load_word_s = hold_r;
        end else begin
            load_word_s = {DATA_WIDTH{1'b0}};
        end
        rx_word_s = rx_shift_r;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_cnt_r == CW'(i)) begin
                rx_word_s[i] = mosi_h_r;
            end else begin
                rx_word_s[i] = rx_shift_r[i];
            end
        end
    end

    // Frame FSM, holding register handshake and all registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            hold_r           <= {DATA_WIDTH{1'b0}};
            hold_full_r      <= 1'b0;
            ready_r          <= 1'b1;
            tx_shift_r       <= {DATA_WIDTH{1'b0}};
            rx_shift_r       <= {DATA_WIDTH{1'b0}};
            bit_cnt_r        <= {CW{1'b0}};
            reload_pending_r <= 1'b0;
            first_lead_r     <= 1'b0;
            miso_r           <= 1'b0;
            oe_r             <= 1'b0;
            data_out_r       <= {DATA_WIDTH{1'b0}};
            done_r           <= 1'b0;
            underrun_r       <= 1'b0;
            abort_r          <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            underrun_r <= 1'b0;
            abort_r    <= 1'b0;
            if (i_data_valid_TX && ready_r) begin
                hold_r      <= i_data_in_TX;
                hold_full_r <= 1'b1;
                ready_r     <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    miso_r <= 1'b0;
                    oe_r   <= 1'b0;
                    if (ss_fall_s) begin
                        state_r <= ST_LOAD;
                        oe_r    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    tx_shift_r <= load_word_s;
                    miso_r     <= load_word_s[0];
                    if (hold_full_r) begin
                        hold_full_r <= 1'b0;
                        ready_r     <= 1'b1;
                    end else begin
                        underrun_r <= 1'b1;
                    end
                    bit_cnt_r        <= {CW{1'b0}};
                    rx_shift_r       <= {DATA_WIDTH{1'b0}};
                    reload_pending_r <= 1'b0;
                    first_lead_r     <= CPHA;
                    state_r          <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (ss_rise_s) begin
                        state_r <= ST_IDLE;
                        oe_r    <= 1'b0;
                        miso_r  <= 1'b0;
                        if (bit_cnt_r != {CW{1'b0}}) begin
                            abort_r <= 1'b1;
                        end
                    end else begin
                        if (sample_edge_s) begin
                            rx_shift_r <= rx_word_s;
                            if (last_sample_s) begin
                                data_out_r       <= rx_word_s;
                                done_r           <= 1'b1;
                                bit_cnt_r        <= {CW{1'b0}};
                                reload_pending_r <= 1'b1;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + CW'(1);
                            end
                        end
                        // A shift edge after a completed frame starts the next word
                        if (shift_edge_s) begin
                            if (reload_pending_r) begin
                                reload_pending_r <= 1'b0;
                                tx_shift_r       <= load_word_s;
                                miso_r           <= load_word_s[0];
                                if (hold_full_r) begin
                                    hold_full_r <= 1'b0;
                                    ready_r     <= 1'b1;
                                end else begin
                                    underrun_r <= 1'b1;
                                end
                            end else if (first_lead_r) begin
                                first_lead_r <= 1'b0;
                            end else begin
                                tx_shift_r <= {1'b0, tx_shift_r[DATA_WIDTH-1:1]};
                                miso_r     <= tx_shift_r[1];
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    oe_r    <= 1'b0;
                    miso_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_MISO          = miso_r;
    assign o_MISO_oe       = oe_r;
    assign o_data_ready_TX = ready_r;
    assign o_data_out      = data_out_r;
    assign o_data_done     = done_r;
    assign o_tx_underrun   = underrun_r;
    assign o_frame_abort   = abort_r;

endmodule

// File: tb/tb_spi_sub.sv
// Bench for spi_sub: a mode-3 and a mode-0 instance driven by a behavioural SPI main,
// with a queue-based scoreboard on received words.
module tb_spi_sub;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          mosi;
    logic          ss0, ss3, sclk0, sclk3;
    logic [DW-1:0] tx_data;
    logic          tx_valid0, tx_valid3;
    logic          miso0, oe0, ready0, done0, underrun0, abort0;
    logic          miso3, oe3, ready3, done3, underrun3, abort3;
    logic [DW-1:0] data_out0, data_out3;

    always #5 clk = ~clk;

    spi_sub #(.DATA_WIDTH(DW), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
        .clk(clk), .reset_n(reset_n), .i_SCLK(sclk3), .i_SS(ss3), .i_MOSI(mosi),
        .o_MISO(miso3), .o_MISO_oe(oe3), .i_data_in_TX(tx_data), .i_data_valid_TX(tx_valid3),
        .o_data_ready_TX(ready3), .o_data_out(data_out3), .o_data_done(done3),
        .o_tx_underrun(underrun3), .o_frame_abort(abort3)
    );

    spi_sub #(.DATA_WIDTH(DW), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .i_SCLK(sclk0), .i_SS(ss0), .i_MOSI(mosi),
        .o_MISO(miso0), .o_MISO_oe(oe0), .i_data_in_TX(tx_data), .i_data_valid_TX(tx_valid0),
        .o_data_ready_TX(ready0), .o_data_out(data_out0), .o_data_done(done0),
        .o_tx_underrun(underrun0), .o_frame_abort(abort0)
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] rx_q[$];
    int            underrun3_cnt = 0, abort3_cnt = 0, done0_cnt = 0;
    int            exp_underrun3 = 0, exp_abort3 = 0;
    logic [DW-1:0] hold_m;
    bit            hold_full_m = 1'b0;
    logic [DW-1:0] last_rx3 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse from the mode-3 instance pops one expected word
    initial begin
        logic [DW-1:0] exp_w;
        forever begin
            @(negedge clk);
            if (done3 === 1'b1) begin
                if (rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done3_unexpected: got done with data %0h, expected no done", data_out3);
                end else begin
                    exp_w = rx_q.pop_front();
                    check("data_out3", data_out3, exp_w);
                end
            end
            if (underrun3 === 1'b1) underrun3_cnt++;
            if (abort3 === 1'b1) abort3_cnt++;
            if (done0 === 1'b1) done0_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tx_load3(input logic [DW-1:0] w);
        int n = 0;
        while (ready3 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready3", ready3, 1);
        tx_data   = w;
        tx_valid3 = 1'b1;
        @(negedge clk);
        tx_valid3 = 1'b0;
        check("ready3_drop", ready3, 0);
        hold_m      = w;
        hold_full_m = 1'b1;
    endtask

    // Behavioural SPI main: MOSI changes with SCLK low, MISO captured just before SCLK rises
    task automatic spi_frame(input bit sel3, input int h, input logic [DW-1:0] mo,
                             input int nbits, output logic [DW-1:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            if (sel3) sclk3 = 1'b0; else sclk0 = 1'b0;
            mosi = mo[i];
            repeat (h) @(negedge clk);
            mi[i] = sel3 ? miso3 : miso0;
            if (sel3) sclk3 = 1'b1; else sclk0 = 1'b1;
            repeat (h) @(negedge clk);
        end
        if (!sel3) begin
            sclk0 = 1'b0;
            repeat (h) @(negedge clk);
        end
    endtask

    task automatic frame3(input int h, input logic [DW-1:0] mo, input bit full);
        logic [DW-1:0] exp_miso, mi;
        exp_miso = hold_full_m ? hold_m : '0;
        if (!hold_full_m) exp_underrun3++;
        hold_full_m = 1'b0;
        if (full) rx_q.push_back(mo);
        spi_frame(1'b1, h, mo, full ? DW : 3, mi);
        if (full) begin
            check("miso_word3", mi, exp_miso);
            last_rx3 = mo;
        end
        check("underrun3_cnt", underrun3_cnt, exp_underrun3);
    endtask

    task automatic ss3_low();
        ss3 = 1'b0;
        repeat (6) @(negedge clk);
        check("oe3_selected", oe3, 1);
    endtask

    task automatic ss3_high(input int h);
        repeat (h) @(negedge clk);
        ss3 = 1'b1;
        repeat (h + 4) @(negedge clk);
        check("oe3_idle", oe3, 0);
        check("miso3_idle", miso3, 0);
        check("abort3_cnt", abort3_cnt, exp_abort3);
        check("rx_pending", rx_q.size(), 0);
    endtask

    initial begin
        logic [DW-1:0] mi, w, mo;
        int            h;
        bit            load, low;

        reset_n = 1'b0; ss0 = 1'b1; ss3 = 1'b1; sclk0 = 1'b0; sclk3 = 1'b1;
        mosi = 1'b0; tx_data = '0; tx_valid0 = 1'b0; tx_valid3 = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_miso", miso3, 0);
        check("rst_oe", oe3, 0);
        check("rst_ready", ready3, 1);
        check("rst_data_out", data_out3, 0);
        check("rst_pulses", {done3, underrun3, abort3}, 0);

        // Mode 3 basic frame
        tx_load3(8'hA5);
        ss3_low();
        frame3(5, 8'h3C, 1'b1);
        ss3_high(5);

        // Mode 0 basic frame on the second instance
        tx_data = 8'h81; tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
        ss0 = 1'b0;
        repeat (6) @(negedge clk);
        check("miso0_pre_edge", miso0, 1);
        spi_frame(1'b0, 5, 8'h7E, DW, mi);
        check("miso_word0", mi, 8'h81);
        check("done0_cnt", done0_cnt, 1);
        check("data_out0", data_out0, 8'h7E);
        ss0 = 1'b1;
        repeat (10) @(negedge clk);

        // Back-to-back frames with SS held low
        tx_load3(8'hF0);
        ss3_low();
        frame3(5, 8'h11, 1'b1);
        tx_load3(8'h0F);
        frame3(5, 8'h22, 1'b1);
        ss3_high(5);

        // Underrun: no TX word loaded
        ss3_low();
        frame3(5, 8'h96, 1'b1);
        ss3_high(5);

        // Abort after 3 bits, then a clean frame
        tx_load3(8'h55);
        ss3_low();
        frame3(5, 8'hE7, 1'b0);
        exp_abort3++;
        ss3_high(5);
        check("data_out3_after_abort", data_out3, last_rx3);
        tx_load3(8'h3A);
        ss3_low();
        frame3(5, 8'hC5, 1'b1);
        ss3_high(5);

        // Reset pulse mid-frame
        tx_load3(8'hC3);
        ss3_low();
        frame3(5, 8'h18, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mid_rst_miso", miso3, 0);
        check("mid_rst_oe", oe3, 0);
        check("mid_rst_ready", ready3, 1);
        check("mid_rst_data_out", data_out3, 0);
        check("mid_rst_pulses", {done3, underrun3, abort3}, 0);
        hold_full_m = 1'b0;
        last_rx3    = '0;
        // SS is still low after reset, so the resynchronized select starts an empty frame
        exp_underrun3++;
        ss3_high(5);
        check("underrun3_after_rst", underrun3_cnt, exp_underrun3);
        tx_load3(8'h6D);
        ss3_low();
        frame3(5, 8'hB2, 1'b1);
        ss3_high(5);

        // Randomized frames, some back-to-back, some without a TX word
        low = 1'b0;
        for (int k = 0; k < 20; k++) begin
            h    = $urandom_range(4, 8);
            load = ($urandom_range(0, 3) != 0);
            w    = DW'($urandom);
            mo   = DW'($urandom);
            if (load) tx_load3(w);
            if (!low) ss3_low();
            frame3(h, mo, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                ss3_high(h);
                low = 1'b0;
            end else begin
                low = 1'b1;
            end
        end
        if (low) ss3_high(5);
        check("final_data_out3", data_out3, last_rx3);
        check("final_underrun3", underrun3_cnt, exp_underrun3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_sub.md
SPI_SUB -- requirements
Module: spi_sub

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per frame (2..16).
REQ-002 SHALL have parameter CPOL, default 1, SCLK idle level.
REQ-003 SHALL have parameter CPHA, default 1, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have clk  input  1  single system clock, all logic on posedge clk.
REQ-005 SHALL have reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have i_SCLK  input  1  SPI clock from main, asynchronous to clk.
REQ-007 SHALL have i_SS  input  1  active-low select from main, asynchronous.
REQ-008 SHALL have i_MOSI  input  1  serial data from main, asynchronous.
REQ-009 SHALL have o_MISO  output  1  serial data to main.
REQ-010 SHALL have o_MISO_oe  output  1  MISO drive enable, 1 only while selected.
REQ-011 SHALL have i_data_in_TX  input  DATA_WIDTH  next word to transmit.
REQ-012 SHALL have i_data_valid_TX  input  1  i_data_in_TX valid.
REQ-013 SHALL have o_data_ready_TX  output  1  TX holding register empty.
REQ-014 SHALL have o_data_out  output  DATA_WIDTH  last complete received word.
REQ-015 SHALL have o_data_done  output  1  one-cycle pulse, o_data_out updated.
REQ-016 SHALL have o_tx_underrun  output  1  one-cycle pulse, frame started with empty holding register.
REQ-017 SHALL have o_frame_abort  output  1  one-cycle pulse, SS deasserted mid-frame.

Function
REQ-018 SHALL pass i_SCLK, i_SS, i_MOSI through two-flop synchronizers plus one history flop; edges detected from synchronized values only.
REQ-019 SHALL define leading edge as SCLK leaving CPOL level, trailing edge as returning to it.
REQ-020 SHALL accept TX word when i_data_valid_TX && o_data_ready_TX; o_data_ready_TX drops next cycle, rises the cycle after the holding register is copied into the shift register.
REQ-021 SHALL implement states IDLE, LOAD, SHIFT; IDLE->LOAD on synchronized SS falling; LOAD->SHIFT after exactly one cycle; SHIFT->IDLE on synchronized SS rising.
REQ-022 SHALL in LOAD copy holding register to TX shift register if full, else load all-zeros and pulse o_tx_underrun; clear bit counter.
REQ-023 SHALL transfer LSB first in both directions; o_MISO shows TX shift bit 0.
REQ-024 SHALL with CPHA=0 present bit 0 on o_MISO from LOAD, sample MOSI on leading edges, shift TX on trailing edges.
REQ-025 SHALL with CPHA=1 shift TX on leading edges (first leading edge presents bit 0 unshifted), sample MOSI on trailing edges.
REQ-026 SHALL store sample n into RX shift bit n; bit counter width ceil(log2(DATA_WIDTH+1)).
REQ-027 SHALL on the DATA_WIDTH-th sample copy the complete word to o_data_out and pulse o_data_done the next cycle; o_data_out holds until the next complete frame.
REQ-028 SHALL with SS held low after a complete frame wrap counter to 0 and reload TX from holding register (same rule as REQ-022) at the first shift edge of the next frame.
REQ-029 SHALL on SS rising with counter not 0 pulse o_frame_abort, discard partial RX bits, leave o_data_out unchanged, no o_data_done.
REQ-030 SHALL hold o_MISO_oe=1 in LOAD and SHIFT, 0 in IDLE; o_MISO=0 when o_MISO_oe=0.
REQ-031 SHALL ignore SCLK edges in IDLE.
REQ-032 SHALL require SCLK half-period >= 4 clk and SS-fall to first SCLK edge >= 5 clk; behaviour outside this is undefined.

Reset
REQ-033 SHALL on reset_n=0 at a clk edge: state IDLE, counters 0, holding register empty, o_data_ready_TX=1, o_MISO=0, o_MISO_oe=0, o_data_out=0, all pulses 0, synchronizers to CPOL/1/0.
REQ-034 SHALL abort any frame in progress on reset without o_frame_abort or o_data_done.

Verification
REQ-035 Mode 3, TX 0xA5 preloaded, main sends 0x3C with SCLK period 10 clk -> main receives 0xA5, o_data_out=0x3C, one o_data_done pulse.
REQ-036 Mode 0, TX 0x81, main sends 0x7E -> o_MISO=1 before first leading edge, main receives 0x81, o_data_out=0x7E.
REQ-037 SS low, two back-to-back frames 0x11 then 0x22, TX 0xF0 then 0x0F loaded -> two done pulses, outputs 0x11/0x22, main receives 0xF0/0x0F.
REQ-038 Frame started with no TX word -> o_tx_underrun pulse, main receives 0x00, RX still correct.
REQ-039 SS raised after 3 bits -> o_frame_abort pulse, o_data_out unchanged, next full frame correct.
REQ-040 reset_n low mid-frame for 1 cycle -> all outputs at reset values next cycle, next full frame correct.
